// File: rtl/entrada_voto.sv
// entrada_voto: vote entry keypad with synchronised, debounced keys, digit editing FSM and seven-segment display
// Ports: clk, rst (sync, active-high); key_inc/key_next/key_corrige/key_confirma (active-low buttons);
//        bcd (current digits), hex (active-low gfedcba per digit), cursor (edited digit), cheio (entry complete),
//        voto (last confirmed vote), voto_valid (confirm pulse), total (saturating confirmed-vote count)
module entrada_voto #(
   parameter int N_DIGITS = 2,
   parameter int DEB_CYCLES = 4,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  key_inc,
   input  logic                  key_next,
   input  logic                  key_corrige,
   input  logic                  key_confirma,
   output logic [4*N_DIGITS-1:0] bcd,
   output logic [7*N_DIGITS-1:0] hex,
   output logic [2:0]            cursor,
   output logic                  cheio,
   output logic [4*N_DIGITS-1:0] voto,
   output logic                  voto_valid,
   output logic [CNT_W-1:0]      total
);
   localparam logic [2:0] CUR_INIT = 3'(N_DIGITS - 1);
   localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
   typedef enum logic {ENTRY, FULL} state_t;
   state_t state_q, state_d;
   logic [3:0] keys, meta_q, meta_d, sync_q, sync_d, lvl_q, lvl_d, prev_q, prev_d, arm_q, arm_d, press;
   logic [1:0] vld_q, vld_d;
   logic [3:0][7:0] cnt_q, cnt_d;
   logic [4*N_DIGITS-1:0] dig_q, dig_d, voto_q, voto_d;
   logic [2:0] cursor_q, cursor_d;
   logic vv_q, vv_d;
   logic [CNT_W-1:0] total_q, total_d;
   logic [3:0] cur_dig;
   logic ev_inc, ev_next, ev_cor, ev_conf, do_conf;

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0: seg = 7'b1000000;
         4'd1: seg = 7'b1111001;
         4'd2: seg = 7'b0100100;
         4'd3: seg = 7'b0110000;
         4'd4: seg = 7'b0011001;
         4'd5: seg = 7'b0010010;
         4'd6: seg = 7'b0000010;
         4'd7: seg = 7'b1111000;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
   endfunction

   assign keys = {key_confirma, key_corrige, key_next, key_inc};

   // vld_q marks when sync_q carries real post-reset samples; a key is armed only
   // once it has been seen released, so a key held through reset gives no press
   always_comb begin
      meta_d = keys;
      sync_d = meta_q;
      vld_d = {vld_q[0], 1'b1};
      prev_d = lvl_q;
      arm_d = arm_q | (sync_q & {4{vld_q[1]}});
      lvl_d = lvl_q;
      for (int k = 0; k < 4; k++) begin
         cnt_d[k] = (sync_q[k] != lvl_q[k]) ? cnt_q[k] + 8'd1 : 8'd0;
         if (sync_q[k] != lvl_q[k] && cnt_q[k] == DEB_LAST) begin
            lvl_d[k] = sync_q[k];
            cnt_d[k] = 8'd0;
         end
      end
      press = arm_q & prev_q & ~lvl_q;
      ev_cor = press[2];
      ev_conf = press[3] & ~press[2];
      ev_next = press[1] & ~|press[3:2];
      ev_inc = press[0] & ~|press[3:1];
      do_conf = ev_conf && state_q == FULL;
   end

   always_comb begin
      state_d = state_q;
      if (ev_cor || do_conf) state_d = ENTRY;
      else if (ev_next && state_q == ENTRY && cursor_q == 3'd0) state_d = FULL;
   end

   always_comb begin
      cur_dig = dig_q[4*int'(cursor_q) +: 4];
      dig_d = dig_q;
      cursor_d = cursor_q;
      voto_d = do_conf ? dig_q : voto_q;
      vv_d = do_conf;
      total_d = (do_conf && !(&total_q)) ? total_q + 1'b1 : total_q;
      if (ev_cor || do_conf) begin
         dig_d = '0;
         cursor_d = CUR_INIT;
      end
      if (ev_next && state_q == ENTRY && cursor_q != 3'd0) cursor_d = cursor_q - 3'd1;
      if (ev_inc && state_q == ENTRY) dig_d[4*int'(cursor_q) +: 4] = (cur_dig == 4'd9) ? 4'd0 : cur_dig + 4'd1;
   end

   always_comb begin
      cheio = state_q == FULL;
      for (int i = 0; i < N_DIGITS; i++)
         hex[7*i +: 7] = (state_q == ENTRY && i < int'(cursor_q)) ? 7'b1111111 : seg(dig_q[4*i +: 4]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '1;
         sync_q <= '1;
         lvl_q <= '1;
         prev_q <= '1;
         arm_q <= '0;
         vld_q <= '0;
         cnt_q <= '0;
         state_q <= ENTRY;
         dig_q <= '0;
         cursor_q <= CUR_INIT;
         voto_q <= '0;
         vv_q <= 1'b0;
         total_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         lvl_q <= lvl_d;
         prev_q <= prev_d;
         arm_q <= arm_d;
         vld_q <= vld_d;
         cnt_q <= cnt_d;
         state_q <= state_d;
         dig_q <= dig_d;
         cursor_q <= cursor_d;
         voto_q <= voto_d;
         vv_q <= vv_d;
         total_q <= total_d;
      end
   end

   assign bcd = dig_q;
   assign cursor = cursor_q;
   assign voto = voto_q;
   assign voto_valid = vv_q;
   assign total = total_q;
endmodule

// File: tb/tb_entrada_voto.sv
// tb_entrada_voto: vector table, directed corner sequences and random presses against a digit-level model
module tb_entrada_voto;
   localparam int DEB = 4;
   localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                       7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   typedef struct {
      logic [3:0] keys;
      logic [7:0] bcd;
      logic [2:0] cur;
      logic       full;
      logic [7:0] voto;
      logic [7:0] total;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic key_inc = 1'b1, key_next = 1'b1, key_corrige = 1'b1, key_confirma = 1'b1;
   logic [7:0] bcd, voto, bcd2, voto2, total;
   logic [13:0] hex, hex2;
   logic [2:0] cursor, cursor2;
   logic cheio, cheio2, voto_valid, vv2;
   logic [1:0] total2;
   int checks = 0, failures = 0, vv_cnt = 0;
   int m_dig[2];
   int m_cur, m_voto, m_tot, m_tot2;
   bit m_full;
   vec_t tbl[24];

   always #5 clk = ~clk;

   entrada_voto #(.N_DIGITS(2), .DEB_CYCLES(DEB), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .key_inc(key_inc), .key_next(key_next), .key_corrige(key_corrige),
      .key_confirma(key_confirma), .bcd(bcd), .hex(hex), .cursor(cursor), .cheio(cheio),
      .voto(voto), .voto_valid(voto_valid), .total(total));

   entrada_voto #(.N_DIGITS(2), .DEB_CYCLES(DEB), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .key_inc(key_inc), .key_next(key_next), .key_corrige(key_corrige),
      .key_confirma(key_confirma), .bcd(bcd2), .hex(hex2), .cursor(cursor2), .cheio(cheio2),
      .voto(voto2), .voto_valid(vv2), .total(total2));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [13:0] hex_of(input logic [7:0] b, input int c, input bit f);
      logic [13:0] h;
      for (int i = 0; i < 2; i++) begin
         int d = int'(b[4*i +: 4]);
         h[7*i +: 7] = (!f && i < c) ? 7'b1111111 : (d > 9 ? 7'b1111111 : SEG[d]);
      end
      return h;
   endfunction

   function automatic void m_reset();
      m_dig[0] = 0;
      m_dig[1] = 0;
      m_cur = 1;
      m_full = 0;
      m_voto = 0;
      m_tot = 0;
      m_tot2 = 0;
   endfunction

   function automatic void m_clear();
      m_dig[0] = 0;
      m_dig[1] = 0;
      m_cur = 1;
      m_full = 0;
   endfunction

   // returns 1 when the press is a confirm that takes effect
   function automatic bit m_press(input logic [3:0] m);
      bit v = 0;
      if (m[2]) m_clear();
      else if (m[3]) begin
         if (m_full) begin
            m_voto = m_dig[1] * 16 + m_dig[0];
            m_tot = (m_tot < 255) ? m_tot + 1 : 255;
            m_tot2 = (m_tot2 < 3) ? m_tot2 + 1 : 3;
            m_clear();
            v = 1;
         end
      end else if (m[1]) begin
         if (!m_full) begin
            if (m_cur > 0) m_cur--;
            else m_full = 1;
         end
      end else if (m[0]) begin
         if (!m_full) m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
      end
      return v;
   endfunction

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (voto_valid) vv_cnt++;
      end
   endtask

   task automatic set_keys(input logic [3:0] m);
      key_inc = ~m[0];
      key_next = ~m[1];
      key_corrige = ~m[2];
      key_confirma = ~m[3];
   endtask

   task automatic press(input logic [3:0] m, input int hold);
      bit exp_vv;
      vv_cnt = 0;
      set_keys(m);
      cyc(hold);
      set_keys(4'b0000);
      cyc(12);
      exp_vv = (hold >= DEB) ? m_press(m) : 1'b0;
      chk("voto_valid_pulses", 64'(vv_cnt), 64'(exp_vv));
   endtask

   task automatic check_model(input string tag);
      logic [7:0] eb;
      eb = 8'(m_dig[1] * 16 + m_dig[0]);
      chk({tag, "_bcd"}, bcd, eb);
      chk({tag, "_cursor"}, cursor, 64'(m_cur));
      chk({tag, "_cheio"}, cheio, 64'(m_full));
      chk({tag, "_voto"}, voto, 64'(m_voto));
      chk({tag, "_total"}, total, 64'(m_tot));
      chk({tag, "_total_sat"}, total2, 64'(m_tot2));
      chk({tag, "_hex"}, hex, hex_of(eb, m_cur, m_full));
      chk({tag, "_voto_valid"}, voto_valid, 0);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_bcd"}, bcd, 8'h00);
      chk({tag, "_cursor"}, cursor, 3'd1);
      chk({tag, "_cheio"}, cheio, 1'b0);
      chk({tag, "_voto"}, voto, 8'h00);
      chk({tag, "_voto_valid"}, voto_valid, 1'b0);
      chk({tag, "_total"}, total, 8'd0);
      chk({tag, "_total_sat"}, total2, 2'd0);
      chk({tag, "_hex"}, hex, 14'b1000000_1111111);
   endtask

   initial begin
      int lat;
      logic [3:0] m;
      tbl[0]  = '{4'b1000, 8'h00, 3'd1, 1'b0, 8'h00, 8'd0};
      tbl[1]  = '{4'b0001, 8'h10, 3'd1, 1'b0, 8'h00, 8'd0};
      tbl[2]  = '{4'b0001, 8'h20, 3'd1, 1'b0, 8'h00, 8'd0};
      tbl[3]  = '{4'b0001, 8'h30, 3'd1, 1'b0, 8'h00, 8'd0};
      tbl[4]  = '{4'b0010, 8'h30, 3'd0, 1'b0, 8'h00, 8'd0};
      tbl[5]  = '{4'b0001, 8'h31, 3'd0, 1'b0, 8'h00, 8'd0};
      tbl[6]  = '{4'b0001, 8'h32, 3'd0, 1'b0, 8'h00, 8'd0};
      tbl[7]  = '{4'b0001, 8'h33, 3'd0, 1'b0, 8'h00, 8'd0};
      tbl[8]  = '{4'b0001, 8'h34, 3'd0, 1'b0, 8'h00, 8'd0};
      tbl[9]  = '{4'b0001, 8'h35, 3'd0, 1'b0, 8'h00, 8'd0};
      tbl[10] = '{4'b0001, 8'h36, 3'd0, 1'b0, 8'h00, 8'd0};
      tbl[11] = '{4'b0001, 8'h37, 3'd0, 1'b0, 8'h00, 8'd0};
      tbl[12] = '{4'b0010, 8'h37, 3'd0, 1'b1, 8'h00, 8'd0};
      tbl[13] = '{4'b0001, 8'h37, 3'd0, 1'b1, 8'h00, 8'd0};
      tbl[14] = '{4'b0010, 8'h37, 3'd0, 1'b1, 8'h00, 8'd0};
      tbl[15] = '{4'b1000, 8'h00, 3'd1, 1'b0, 8'h37, 8'd1};
      tbl[16] = '{4'b0001, 8'h10, 3'd1, 1'b0, 8'h37, 8'd1};
      tbl[17] = '{4'b0101, 8'h00, 3'd1, 1'b0, 8'h37, 8'd1};
      tbl[18] = '{4'b0011, 8'h00, 3'd0, 1'b0, 8'h37, 8'd1};
      tbl[19] = '{4'b1010, 8'h00, 3'd0, 1'b0, 8'h37, 8'd1};
      tbl[20] = '{4'b0010, 8'h00, 3'd0, 1'b1, 8'h37, 8'd1};
      tbl[21] = '{4'b1100, 8'h00, 3'd1, 1'b0, 8'h37, 8'd1};
      tbl[22] = '{4'b1111, 8'h00, 3'd1, 1'b0, 8'h37, 8'd1};
      tbl[23] = '{4'b0010, 8'h00, 3'd0, 1'b0, 8'h37, 8'd1};
      m_reset();
      cyc(3);
      check_reset("in_rst");
      rst = 1'b0;
      cyc(5);
      check_reset("post_rst");
      for (int i = 0; i < 24; i++) begin
         press(tbl[i].keys, 6);
         chk($sformatf("vec%0d_bcd", i), bcd, tbl[i].bcd);
         chk($sformatf("vec%0d_cursor", i), cursor, tbl[i].cur);
         chk($sformatf("vec%0d_cheio", i), cheio, tbl[i].full);
         chk($sformatf("vec%0d_voto", i), voto, tbl[i].voto);
         chk($sformatf("vec%0d_total", i), total, tbl[i].total);
         chk($sformatf("vec%0d_hex", i), hex, hex_of(tbl[i].bcd, int'(tbl[i].cur), tbl[i].full));
         if (i == 12) chk("full_hex_37", hex, 14'b0110000_1111000);
      end
      press(4'b0100, 6);
      key_inc = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         cyc(1);
         if (bcd != 8'h00) begin
            lat = n;
            break;
         end
      end
      chk("inc_latency_edges", 64'(lat), 7);
      cyc(3);
      key_inc = 1'b1;
      cyc(12);
      void'(m_press(4'b0001));
      check_model("latency");
      key_inc = 1'b0;
      cyc(3);
      key_inc = 1'b1;
      cyc(12);
      check_model("glitch3");
      press(4'b0001, 4);
      check_model("low4");
      press(4'b0001, 100);
      check_model("hold100");
      chk("hold100_bcd", bcd, 8'h30);
      press(4'b0100, 6);
      repeat (10) press(4'b0001, 6);
      chk("wrap10_bcd", bcd, 8'h00);
      press(4'b0001, 6);
      chk("wrap11_bcd", bcd, 8'h10);
      press(4'b0100, 6);
      for (int i = 0; i < 5; i++) begin
         press(4'b0010, 6);
         press(4'b0010, 6);
         press(4'b1000, 6);
      end
      chk("sat_total", total2, 2'd3);
      check_model("sat");
      for (int i = 0; i < 150; i++) begin
         int r = $urandom_range(0, 9);
         m = r < 4 ? 4'b0001 : r < 7 ? 4'b0010 : r == 7 ? 4'b1000 : r == 8 ? 4'b0100 : 4'($urandom_range(1, 15));
         press(m, ($urandom_range(0, 7) == 0) ? $urandom_range(1, DEB - 1) : $urandom_range(DEB, 9));
         check_model($sformatf("rand%0d", i));
      end
      press(4'b0100, 6);
      repeat (5) press(4'b0001, 6);
      press(4'b0010, 6);
      repeat (2) press(4'b0001, 6);
      press(4'b0010, 6);
      chk("pre_rst_bcd", bcd, 8'h52);
      chk("pre_rst_cheio", cheio, 1'b1);
      rst = 1'b1;
      cyc(2);
      check_reset("full_rst");
      rst = 1'b0;
      m_reset();
      cyc(3);
      check_model("after_rst");
      key_inc = 1'b0;
      rst = 1'b1;
      cyc(3);
      rst = 1'b0;
      cyc(30);
      chk("held_through_rst_bcd", bcd, 8'h00);
      key_inc = 1'b1;
      cyc(12);
      chk("held_release_bcd", bcd, 8'h00);
      press(4'b0001, 6);
      chk("repress_bcd", bcd, 8'h10);
      check_model("final");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
